// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative signed multiply/divide sequencer.
package muldiv_pkg;
    typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;
    localparam int   ITER    = 32;
endpackage

// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply (shift-add) and divide (restoring) on magnitudes,
// with sign correction applied once at the end of the run.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start; operands and op latched on start
//   PREP  | capture magnitudes and sign flags, clear iteration counter
//   RUN   | one iteration per cycle, 32 cycles
//   FIX   | sign-correct and register hi/lo (skipped write on div by zero)
//   DONE  | one-cycle done pulse, back to IDLE
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    state_t             state;
    logic               op_q, neg_res, neg_rem, dz_q;
    logic [WIDTH-1:0]   a_q, b_q, mag_a, mag_b, work_hi, work_lo;
    logic [4:0]         cnt;
    logic [WIDTH:0]     add_sum, shifted, diff;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Unsigned magnitude: the most negative value maps onto itself.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    always_comb begin
        add_sum  = {1'b0, work_hi} + {1'b0, (work_lo[0] ? mag_a : {WIDTH{1'b0}})};
        shifted  = {work_hi, work_lo[WIDTH-1]};
        diff     = shifted - {1'b0, mag_b};
        prod     = {work_hi, work_lo};
        prod_fix = neg_res ? -prod : prod;
        quo_fix  = neg_res ? -work_lo : work_lo;
        rem_fix  = neg_rem ? -work_hi : work_hi;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            op_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            mag_a    <= '0;
            mag_b    <= '0;
            work_hi  <= '0;
            work_lo  <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            dz_q     <= 1'b0;
            cnt      <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        a_q   <= a;
                        b_q   <= b;
                        busy  <= 1'b1;
                        state <= PREP;
                    end
                end
                PREP: begin
                    mag_a   <= magnitude(a_q);
                    mag_b   <= magnitude(b_q);
                    neg_res <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
                    neg_rem <= a_q[WIDTH-1];
                    cnt     <= '0;
                    work_hi <= '0;
                    work_lo <= (op_q == OP_DIV) ? magnitude(a_q) : magnitude(b_q);
                    dz_q    <= (op_q == OP_DIV) && (b_q == '0);
                    // Divide-by-zero bypasses RUN; FIX only emits the flag.
                    state   <= ((op_q == OP_DIV) && (b_q == '0)) ? FIX : RUN;
                end
                RUN: begin
                    if (op_q == OP_MULT) begin
                        work_hi <= add_sum[WIDTH:1];
                        work_lo <= {add_sum[0], work_lo[WIDTH-1:1]};
                    end else if (!diff[WIDTH]) begin
                        work_hi <= diff[WIDTH-1:0];
                        work_lo <= {work_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        work_hi <= shifted[WIDTH-1:0];
                        work_lo <= {work_lo[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(ITER - 1)) state <= FIX;
                end
                FIX: begin
                    if (dz_q) begin
                        div_zero <= 1'b1;
                    end else if (op_q == OP_MULT) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer against a plain-arithmetic reference.
module tb_muldiv_sequencer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        op    = 1'b0;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    task automatic ref_model(input logic o, input logic [31:0] x, y,
                             input logic [31:0] ph, pl,
                             output logic [31:0] h, l, output logic dz);
        longint sa, sb, p, q, r;
        sa = longint'($signed(x));
        sb = longint'($signed(y));
        dz = 1'b0;
        if (o == 1'b0) begin
            p = sa * sb;
            h = p[63:32];
            l = p[31:0];
        end else if (y == 32'd0) begin
            dz = 1'b1;
            h = ph;
            l = pl;
        end else begin
            q = sa / sb;
            r = sa % sb;
            h = r[31:0];
            l = q[31:0];
        end
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 6))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'(int'($urandom_range(0, 40)) - 20);
            default: return $urandom;
        endcase
    endfunction

    // Waits for done, starting right after edge k+base; lat = n where done is
    // high in the cycle after edge k+n, or -1 on timeout.
    task automatic wait_done(input int base, output int lat, output logic busy0);
        int n;
        n = base;
        lat = -1;
        busy0 = 1'bx;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (i == 0) busy0 = busy;
            if (done) begin
                lat = n;
                break;
            end
            n++;
        end
    endtask

    task automatic run_op(input logic o, input logic [31:0] x, y, output int lat,
                          output logic [31:0] h, l, output logic dz,
                          output logic busy0, done_nx, busy_nx);
        @(posedge clock); #1;
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        op = 1'($urandom); a = $urandom; b = $urandom;
        wait_done(0, lat, busy0);
        h = hi; l = lo; dz = div_zero;
        @(negedge clock);
        done_nx = done; busy_nx = busy;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd4;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz: got %b expected 0", div_zero); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
        start = 1'b0;
        reset = 1'b0;
        exp_hi = '0; exp_lo = '0;
    endtask

    task automatic test_directed();
        int lat;
        logic [31:0] h, l;
        logic dz, b0, dn, bn;
        run_op(1'b0, 32'd7, 32'hFFFF_FFFD, lat, h, l, dz, b0, dn, bn);
        checks++; if (lat !== 34) begin errors++; $display("FAIL mult_lat: got %0d expected 34", lat); end
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL mult_busy: got %b expected 1", b0); end
        checks++; if (h !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", h); end
        checks++; if (l !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo: got %h expected ffffffeb", l); end
        checks++; if (dn !== 1'b0 || bn !== 1'b0) begin errors++; $display("FAIL mult_pulse: got done=%b busy=%b expected 0 0", dn, bn); end
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat, h, l, dz, b0, dn, bn);
        checks++; if (lat !== 34) begin errors++; $display("FAIL div_lat: got %0d expected 34", lat); end
        checks++; if (l !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h expected fffffffd", l); end
        checks++; if (h !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h expected ffffffff", h); end
        checks++; if (dz !== 1'b0) begin errors++; $display("FAIL div_dz: got %b expected 0", dz); end
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, h, l, dz, b0, dn, bn);
        checks++; if (l !== 32'h8000_0000 || h !== 32'd0 || dz !== 1'b0) begin
            errors++; $display("FAIL div_min: got hi=%h lo=%h dz=%b expected 0 80000000 0", h, l, dz); end
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, h, l, dz, b0, dn, bn);
        checks++; if (h !== 32'd0 || l !== 32'd1) begin
            errors++; $display("FAIL mult_m1: got hi=%h lo=%h expected 0 1", h, l); end
        exp_hi = 32'd0; exp_lo = 32'd1;
    endtask

    task automatic test_div_zero();
        int lat;
        logic [31:0] h, l;
        logic dz, b0, dn, bn;
        run_op(1'b1, 32'h451, 32'h20, lat, h, l, dz, b0, dn, bn);
        checks++; if (h !== 32'h11 || l !== 32'h22) begin
            errors++; $display("FAIL dz_setup: got hi=%h lo=%h expected 11 22", h, l); end
        run_op(1'b1, 32'd5, 32'd0, lat, h, l, dz, b0, dn, bn);
        checks++; if (lat !== 2) begin errors++; $display("FAIL dz_lat: got %0d expected 2", lat); end
        checks++; if (dz !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b expected 1", dz); end
        checks++; if (h !== 32'h11 || l !== 32'h22) begin
            errors++; $display("FAIL dz_hold: got hi=%h lo=%h expected 11 22", h, l); end
        checks++; if (bn !== 1'b0 || dn !== 1'b0) begin
            errors++; $display("FAIL dz_after: got busy=%b done=%b expected 0 0", bn, dn); end
        exp_hi = 32'h11; exp_lo = 32'h22;
    endtask

    task automatic test_random();
        int lat;
        logic [31:0] x, y, h, l, eh, el;
        logic o, dz, edz, b0, dn, bn;
        for (int i = 0; i < 30; i++) begin
            o = 1'($urandom_range(0, 1));
            x = pick_val();
            y = pick_val();
            if (i % 7 == 3) begin o = 1'b1; y = 32'd0; end
            ref_model(o, x, y, exp_hi, exp_lo, eh, el, edz);
            run_op(o, x, y, lat, h, l, dz, b0, dn, bn);
            checks++; if (lat !== (edz ? 2 : 34)) begin
                errors++; $display("FAIL rnd_lat[%0d]: got %0d expected %0d", i, lat, edz ? 2 : 34); end
            checks++; if (h !== eh || l !== el || dz !== edz) begin
                errors++; $display("FAIL rnd_res[%0d] op=%b a=%h b=%h: got %h_%h dz=%b expected %h_%h dz=%b",
                                   i, o, x, y, h, l, dz, eh, el, edz); end
            checks++; if (dn !== 1'b0) begin errors++; $display("FAIL rnd_pulse[%0d]: got done=%b expected 0", i, dn); end
            exp_hi = eh; exp_lo = el;
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        logic [31:0] eh, el;
        logic edz, b0;
        ref_model(1'b0, 32'h1234_5678, 32'hFEDC_BA98, exp_hi, exp_lo, eh, el, edz);
        @(posedge clock); #1;
        op = 1'b0; a = 32'h1234_5678; b = 32'hFEDC_BA98; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        start = 1'b1; op = 1'b1; a = $urandom; b = 32'd3;
        @(posedge clock); #1;
        start = 1'b0;
        wait_done(7, lat, b0);
        checks++; if (lat !== 34) begin errors++; $display("FAIL ign_lat: got %0d expected 34", lat); end
        checks++; if (hi !== eh || lo !== el) begin
            errors++; $display("FAIL ign_res: got %h_%h expected %h_%h", hi, lo, eh, el); end
        @(negedge clock);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL ign_after: got busy=%b done=%b expected 0 0", busy, done); end
        exp_hi = eh; exp_lo = el;
    endtask

    task automatic test_reset_mid();
        logic saw_done;
        @(posedge clock); #1;
        op = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0000_1357; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (11) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL rmid_ctl: got busy=%b done=%b expected 0 0", busy, done); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin
            errors++; $display("FAIL rmid_res: got %h_%h expected 0_0", hi, lo); end
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (done || busy) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rmid_quiet: got activity=%b expected 0", saw_done); end
        exp_hi = '0; exp_lo = '0;
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] eh1, el1, eh2, el2;
        logic edz, b0;
        ref_model(1'b0, 32'hFFFF_8000, 32'h0001_0003, exp_hi, exp_lo, eh1, el1, edz);
        ref_model(1'b1, 32'h7654_3210, 32'hFFFF_FF13, eh1, el1, eh2, el2, edz);
        @(posedge clock); #1;
        op = 1'b0; a = 32'hFFFF_8000; b = 32'h0001_0003; start = 1'b1;
        @(posedge clock); #1;
        op = 1'b1; a = 32'h7654_3210; b = 32'hFFFF_FF13;
        wait_done(0, lat, b0);
        checks++; if (lat !== 34 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_first: got lat=%0d busy=%b expected 34 0", lat, busy); end
        checks++; if (hi !== eh1 || lo !== el1) begin
            errors++; $display("FAIL b2b_res1: got %h_%h expected %h_%h", hi, lo, eh1, el1); end
        @(negedge clock);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL b2b_idle: got busy=%b done=%b expected 0 0", busy, done); end
        @(negedge clock);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_prep: got busy=%b expected 1", busy); end
        start = 1'b0;
        wait_done(37, lat, b0);
        checks++; if (lat !== 70) begin errors++; $display("FAIL b2b_lat2: got %0d expected 70", lat); end
        checks++; if (hi !== eh2 || lo !== el2 || div_zero !== 1'b0) begin
            errors++; $display("FAIL b2b_res2: got %h_%h dz=%b expected %h_%h dz=0", hi, lo, div_zero, eh2, el2); end
        @(negedge clock);
        exp_hi = eh2; exp_lo = el2;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
